// File: rtl/comparer.sv
// -----------------------------------------------------------------------------
// comparer
//
// Flag-based comparison stage placed directly after the ALU adder/subtractor.
// It takes the ALU status flags and the subtraction result (a - b) and
// produces registered equal / signed-less-than / unsigned-less-than
// indications for set-on-less-than and branch resolution. It also reports
// when the zero flag disagrees with the actual result value.
//
// Parameters:
//   WIDTH     - bit width of a, b and result (default 1)
//
// Ports:
//   clk       in   1      rising-edge clock
//   reset     in   1      synchronous, active-high reset
//   a         in   WIDTH  operand A (debug / interface uniformity only)
//   b         in   WIDTH  operand B (debug / interface uniformity only)
//   result    in   WIDTH  ALU result of a - b
//   cout      in   1      adder carry-out, 1 = no borrow
//   zero      in   1      ALU zero flag
//   sign      in   1      ALU sign flag
//   overflow  in   1      ALU signed-overflow flag
//   eql       out  1      registered: a == b
//   slt       out  1      registered: a < b (signed)
//   sltu      out  1      registered: a < b (unsigned)
//   flag_err  out  1      registered: zero flag disagrees with result
//
// Timing: no handshake and no enable. Every rising edge samples the inputs;
// the decoded flags are visible after that edge and hold until the next one
// (latency exactly 1 clock). Reset wins over the sample on the same edge.
// -----------------------------------------------------------------------------
module comparer #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] result,
    input  logic             cout,
    input  logic             zero,
    input  logic             sign,
    input  logic             overflow,
    output logic             eql,
    output logic             slt,
    output logic             sltu,
    output logic             flag_err
);

    // Operands are carried for interface uniformity and debug visibility only;
    // the decode relies purely on the ALU flags and result.
    logic unused_operands;
    assign unused_operands = ^{a, b};

    logic result_is_zero;
    logic eql_next;
    logic slt_next;
    logic sltu_next;
    logic flag_err_next;

    // Flags are trusted as delivered by the ALU; sign is deliberately not
    // re-derived from result[WIDTH-1], so inconsistent flag sets pass through.
    always_comb begin
        result_is_zero = (result == '0);
        eql_next       = zero;
        slt_next       = sign ^ overflow;   // signed compare: true sign of a-b
        sltu_next      = ~cout;             // borrow out means a < b unsigned
        flag_err_next  = zero ^ result_is_zero;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            eql      <= 1'b0;
            slt      <= 1'b0;
            sltu     <= 1'b0;
            flag_err <= 1'b0;
        end else begin
            eql      <= eql_next;
            slt      <= slt_next;
            sltu     <= sltu_next;
            flag_err <= flag_err_next;
        end
    end

endmodule

// File: tb/tb_comparer.sv
// -----------------------------------------------------------------------------
// tb_comparer
//
// Drives a WIDTH=1 and a WIDTH=8 comparer with identical flags (the 1-bit
// instance sees result[0]). Expected values come from a table of hand-derived
// vectors and from a flag-rule reference model for random stimulus; both feed
// an expected queue that is popped one edge later.
// -----------------------------------------------------------------------------
module tb_comparer;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [7:0] a8, b8, res8;
    logic       a1, b1, res1;
    logic       cout, zero, sign, overflow;

    logic eql1, slt1, sltu1, ferr1;
    logic eql8, slt8, sltu8, ferr8;

    comparer #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .a(a1), .b(b1), .result(res1),
        .cout(cout), .zero(zero), .sign(sign), .overflow(overflow),
        .eql(eql1), .slt(slt1), .sltu(sltu1), .flag_err(ferr1)
    );

    comparer #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .a(a8), .b(b8), .result(res8),
        .cout(cout), .zero(zero), .sign(sign), .overflow(overflow),
        .eql(eql8), .slt(slt8), .sltu(sltu8), .flag_err(ferr8)
    );

    // expected bits: {eql, slt, sltu, flag_err(W=1), flag_err(W=8)}
    typedef struct {
        logic       rst;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       cout;
        logic       zero;
        logic       sign;
        logic       ovf;
        logic [4:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [4:0] exp_q[$];
    logic [4:0] last_exp;
    logic       have_last;
    int         n_checks;
    int         n_fail;

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [4:0] e);
        chk({tag, " eql1"},  eql1,  e[4]);
        chk({tag, " slt1"},  slt1,  e[3]);
        chk({tag, " sltu1"}, sltu1, e[2]);
        chk({tag, " ferr1"}, ferr1, e[1]);
        chk({tag, " eql8"},  eql8,  e[4]);
        chk({tag, " slt8"},  slt8,  e[3]);
        chk({tag, " sltu8"}, sltu8, e[2]);
        chk({tag, " ferr8"}, ferr8, e[0]);
    endtask

    // Reference model: straight from the flag rules, per width.
    function automatic logic [4:0] model(input vec_t v);
        logic eq, lt, ltu, f1, f8;
        if (v.rst) return 5'b00000;
        eq  = v.zero;
        lt  = (v.sign != v.ovf);
        ltu = (v.cout == 1'b0);
        f1  = (v.zero != (v.res % 2 == 0));
        f8  = (v.zero != (v.res == 8'd0));
        return {eq, lt, ltu, f1, f8};
    endfunction

    function automatic vec_t mk(input logic rst, input logic [7:0] a, input logic [7:0] b,
                                input logic [7:0] res, input logic co, input logic z,
                                input logic s, input logic o, input logic [4:0] e);
        vec_t v;
        v.rst = rst; v.a = a; v.b = b; v.res = res;
        v.cout = co; v.zero = z; v.sign = s; v.ovf = o; v.exp = e;
        return v;
    endfunction

    // ---------------- driver ----------------
    // Drive on the falling edge, confirm the previous result still holds,
    // then check the new result just after the rising edge.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        reset    = v.rst;
        a8       = v.a;   b8 = v.b;   res8 = v.res;
        a1       = v.a[0]; b1 = v.b[0]; res1 = v.res[0];
        cout     = v.cout; zero = v.zero; sign = v.sign; overflow = v.ovf;
        exp_q.push_back(v.exp);
        #1;
        if (have_last) chk_all({tag, " hold"}, last_exp);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, " queue_empty"}, 1'b1, 1'b0);
        end else begin
            last_exp  = exp_q.pop_front();
            have_last = 1'b1;
            chk_all(tag, last_exp);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        have_last = 1'b0;
        last_exp  = 5'b0;
        reset = 1'b1; a8 = '0; b8 = '0; res8 = '0; a1 = 0; b1 = 0; res1 = 0;
        cout = 0; zero = 0; sign = 0; overflow = 0;

        //            rst a      b      res    co z  s  o  exp{eq,lt,ltu,f1,f8}
        // reset held two cycles with all inputs high
        vecs.push_back(mk(1, 8'hFF, 8'hFF, 8'hFF, 1, 1, 1, 1, 5'b00000));
        vecs.push_back(mk(1, 8'hFF, 8'hFF, 8'hFF, 1, 1, 1, 1, 5'b00000));
        // all inputs zero
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 5'b00111));
        // signed sweep {sign,overflow} = 00,10,11,01
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 0, 5'b00011));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 1, 0, 1, 0, 5'b01011));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 1, 0, 1, 1, 5'b00011));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 1, 0, 0, 1, 5'b01011));
        // consistency with result=1
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h01, 1, 0, 0, 0, 5'b00000));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h01, 1, 0, 0, 1, 5'b01000));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h01, 1, 1, 0, 0, 5'b10011));
        // reset priority, then release: result one edge later
        vecs.push_back(mk(1, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0, 5'b00000));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 1, 1, 0, 0, 5'b10000));
        // 8-bit operands
        vecs.push_back(mk(0, 8'h05, 8'h05, 8'h00, 1, 1, 0, 0, 5'b10000));
        vecs.push_back(mk(0, 8'h03, 8'h07, 8'hFC, 0, 0, 1, 0, 5'b01110));
        // only the MSB set: full-width zero detect on the 8-bit instance
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h80, 1, 0, 1, 1, 5'b00010));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h80, 1, 1, 0, 0, 5'b10001));
        // mid-stream reset discards the in-flight sample
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h00, 0, 1, 1, 0, 5'b11100));
        vecs.push_back(mk(1, 8'h00, 8'h00, 8'h00, 0, 1, 1, 0, 5'b00000));
        vecs.push_back(mk(0, 8'h00, 8'h00, 8'h10, 0, 0, 0, 1, 5'b01110));

        foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

        // randomized stimulus against the reference model
        for (int i = 0; i < 400; i++) begin
            vec_t v;
            v.rst  = ($urandom_range(0, 15) == 0);
            v.a    = 8'($urandom_range(0, 255));
            v.b    = 8'($urandom_range(0, 255));
            // bias toward zero and single-bit results to hit the zero detect
            case ($urandom_range(0, 3))
                0:       v.res = 8'h00;
                1:       v.res = 8'(1 << $urandom_range(0, 7));
                default: v.res = 8'($urandom_range(0, 255));
            endcase
            v.cout = 1'($urandom_range(0, 1));
            v.zero = 1'($urandom_range(0, 1));
            v.sign = 1'($urandom_range(0, 1));
            v.ovf  = 1'($urandom_range(0, 1));
            v.exp  = model(v);
            apply(v, $sformatf("rnd%0d", i));
        end

        if (exp_q.size() != 0) chk("queue_drained", 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/comparer.md
Name: comparer

Overview:
Flag-based comparison stage that sits directly after the ALU adder/subtractor. It consumes the operands, the subtraction result (a - b) and the ALU status flags, and produces registered equality, signed less-than and unsigned less-than indications for set-on-less-than and branch logic. It also flags any inconsistency between the zero flag and the actual result value.

Parameters:
- WIDTH, default 1, bit width of operands a, b and result.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- a  input  WIDTH  ALU operand A (informational; not used in flag decode).
- b  input  WIDTH  ALU operand B (informational; not used in flag decode).
- result  input  WIDTH  ALU result of a - b.
- cout  input  1  adder carry-out; 1 means no borrow.
- zero  input  1  ALU zero flag.
- sign  input  1  ALU sign flag (MSB of result).
- overflow  input  1  ALU signed-overflow flag.
- eql  output  1  registered: operands equal.
- slt  output  1  registered: a < b, signed.
- sltu  output  1  registered: a < b, unsigned.
- flag_err  output  1  registered: zero flag disagrees with result.

Behaviour:
- Purely combinational decode, registered once. Latency is exactly 1 clock: inputs sampled on rising edge N appear on the outputs after edge N and hold until edge N+1.
- Decode rules:
  - eql_next = zero.
  - slt_next = sign XOR overflow.
  - sltu_next = NOT cout.
  - flag_err_next = zero XOR (result == 0), with result compared across all WIDTH bits.
- a and b do not affect any output. They are kept on the port list for interface uniformity and debug.
- Flags are trusted as given. sign is not re-derived from result[WIDTH-1].
- Reset is synchronous. With reset high on a rising edge, eql, slt, sltu and flag_err all become 0 regardless of inputs. Reset has priority over the input sample.
- Deasserting reset: the first sample is taken on the first rising edge with reset low, and outputs reflect it after that edge.
- Reset asserted mid-stream discards the in-flight sample. No other state exists.
- There is no enable or handshake. The block samples on every cycle.
- Inputs that are X or Z are not defined. Outputs may go X; no masking is required.
- Every combination of the 7 flag/result inputs is legal, including inconsistent ones such as zero=1 with sign=1.

Test Plan:
- Reset: hold reset=1 for 2 cycles with all inputs at 1 -> eql=0, slt=0, sltu=0, flag_err=0 after each edge.
- All inputs 0 (WIDTH=1, result=0, cout=0, zero=0, sign=0, overflow=0) -> after one edge: eql=0, slt=0, sltu=1, flag_err=1.
- Signed decode with result=0, cout=1, zero=0, sweeping {sign, overflow} through 00, 10, 11, 01 on consecutive cycles -> slt = 0, 1, 0, 1 respectively, each one cycle after its input; sltu=0 and flag_err=1 throughout.
- Consistency with result=1, cout=1, zero=0, sign=0, overflow=0 and then overflow=1 -> slt = 0 then 1, eql=0, flag_err=0; then result=1 with zero=1 -> eql=1, flag_err=1.
- Latency and reset priority: apply zero=1, result=0 together with reset=1 -> outputs stay 0. Release reset -> eql=1 and flag_err=0 appear exactly one edge later.
- WIDTH=8: a=5, b=5, result=0, cout=1, zero=1 -> eql=1, slt=0, sltu=0, flag_err=0. Then a=3, b=7, result=8'hFC, cout=0, sign=1, overflow=0, zero=0 -> slt=1, sltu=1, eql=0, flag_err=0.
